// File: rtl/accel_pkg.sv
// -----------------------------------------------------------------------------
// accel_pkg
// Shared definitions for the accelerator burst master: FSM state encoding,
// OP_MODE transform codes and the Avalon word size in bytes.
// -----------------------------------------------------------------------------
package accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_WR_BURST,
    ST_NEXT,
    ST_FINISH
  } state_t;

  localparam logic [1:0] OP_COPY  = 2'd0;
  localparam logic [1:0] OP_NOT   = 2'd1;
  localparam logic [1:0] OP_BSWAP = 2'd2;
  localparam logic [1:0] OP_INC   = 2'd3;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/accel_burst_master_burst_buffer.sv
// -----------------------------------------------------------------------------
// burst_buffer
// Staging RAM holding exactly one burst of words between the read phase and
// the write phase. Simple dual-port: one synchronous write port, one
// combinational read port. Contents are not reset; only the indices that
// address it are control state.
//
// Ports
//   CSI_CLOCK_CLK  in   clock
//   we             in   write enable
//   waddr          in   write index
//   wdata          in   write data
//   raddr          in   read index
//   rdata          out  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module burst_buffer
  import accel_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 3
) (
  input  logic                  CSI_CLOCK_CLK,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CSI_CLOCK_CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/accel_burst_master.sv
// -----------------------------------------------------------------------------
// accel_burst_master
// Avalon-MM burst master that copies WORD_COUNT words from SRC_ADDR to
// DST_ADDR on a START rising edge, transforming each word by OP_MODE. Each
// chunk of up to MAX_BURST words is read as one burst into a local buffer and
// then written out as one burst; read and write bursts never overlap.
//
// Ports
//   CSI_CLOCK_CLK      in   clock
//   CSI_CLOCK_RESET    in   asynchronous active-high reset
//   START              in   launch level; job starts on its rising edge
//   SRC_ADDR           in   source byte address (low 2 bits ignored)
//   DST_ADDR           in   destination byte address (low 2 bits ignored)
//   WORD_COUNT         in   number of 32-bit words to move
//   OP_MODE            in   0 copy, 1 NOT, 2 byte-swap, 3 increment
//   DONE               out  sticky job-complete flag
//   BUSY               out  job in progress
//   AVM_ADDRESS        out  master byte address (word aligned)
//   AVM_READ           out  read request
//   AVM_WRITE          out  write request
//   AVM_BURSTCOUNT     out  words in current burst
//   AVM_WRITEDATA      out  write data
//   AVM_WAITREQUEST    in   slave stall
//   AVM_READDATA       in   read data
//   AVM_READDATAVALID  in   read data qualifier
// -----------------------------------------------------------------------------
module accel_burst_master
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  parameter int BC_WIDTH   = 4
) (
  input  logic                  CSI_CLOCK_CLK,
  input  logic                  CSI_CLOCK_RESET,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] SRC_ADDR,
  input  logic [ADDR_WIDTH-1:0] DST_ADDR,
  input  logic [31:0]           WORD_COUNT,
  input  logic [1:0]            OP_MODE,
  output logic                  DONE,
  output logic                  BUSY,
  output logic [ADDR_WIDTH-1:0] AVM_ADDRESS,
  output logic                  AVM_READ,
  output logic                  AVM_WRITE,
  output logic [BC_WIDTH-1:0]   AVM_BURSTCOUNT,
  output logic [DATA_WIDTH-1:0] AVM_WRITEDATA,
  input  logic                  AVM_WAITREQUEST,
  input  logic [DATA_WIDTH-1:0] AVM_READDATA,
  input  logic                  AVM_READDATAVALID
);

  localparam int IDX_W = BC_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORD_BYTES - 1);

  state_t                state;
  logic                  start_q;
  logic                  launch;
  logic [ADDR_WIDTH-1:0] src_ptr;
  logic [ADDR_WIDTH-1:0] dst_ptr;
  logic [31:0]           remaining;
  logic [1:0]            op_mode;
  logic [BC_WIDTH-1:0]   len;
  logic [BC_WIDTH-1:0]   wr_idx;
  logic [BC_WIDTH-1:0]   rd_idx;
  logic [ADDR_WIDTH-1:0] step_bytes;
  logic [ADDR_WIDTH-1:0] src_step;
  logic [ADDR_WIDTH-1:0] dst_step;
  logic [31:0]           rem_after;
  logic                  buf_we;
  logic [DATA_WIDTH-1:0] buf_wdata;
  logic [DATA_WIDTH-1:0] buf_rdata;

  // Burst length for a given number of words still to move.
  function automatic logic [BC_WIDTH-1:0] burst_len(input logic [31:0] rem);
    if (rem >= 32'(MAX_BURST)) return BC_WIDTH'(MAX_BURST);
    else                       return rem[BC_WIDTH-1:0];
  endfunction

  // Per-word transform applied as read data enters the buffer.
  function automatic logic [DATA_WIDTH-1:0] apply_op(input logic [1:0] mode,
                                                     input logic [DATA_WIDTH-1:0] d);
    case (mode)
      OP_NOT:   return ~d;
      OP_BSWAP: return {d[7:0], d[15:8], d[23:16], d[31:24]};
      OP_INC:   return d + DATA_WIDTH'(1);
      default:  return d;
    endcase
  endfunction

  // A launch is only honoured while no job is running.
  assign launch     = START & ~start_q & ((state == ST_IDLE) | (state == ST_FINISH));
  assign step_bytes = ADDR_WIDTH'(len) * ADDR_WIDTH'(WORD_BYTES);
  assign src_step   = src_ptr + step_bytes;
  assign dst_step   = dst_ptr + step_bytes;
  assign rem_after  = remaining - 32'(len);

  assign buf_we    = (state == ST_RD_DATA) & AVM_READDATAVALID;
  assign buf_wdata = apply_op(op_mode, AVM_READDATA);

  assign BUSY          = (state != ST_IDLE) & (state != ST_FINISH);
  // Gated so the bus sees zero outside a write burst (buffer is never reset).
  assign AVM_WRITEDATA = (state == ST_WR_BURST) ? buf_rdata : '0;

  burst_buffer #(
    .DEPTH      (MAX_BURST),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_buf (
    .CSI_CLOCK_CLK (CSI_CLOCK_CLK),
    .we            (buf_we),
    .waddr         (wr_idx[IDX_W-1:0]),
    .wdata         (buf_wdata),
    .raddr         (rd_idx[IDX_W-1:0]),
    .rdata         (buf_rdata)
  );

  // Job parameters: latched at launch, advanced once per burst.
  always_ff @(posedge CSI_CLOCK_CLK) begin
    if (launch) begin
      src_ptr   <= SRC_ADDR & ALIGN_MASK;
      dst_ptr   <= DST_ADDR & ALIGN_MASK;
      remaining <= WORD_COUNT;
      op_mode   <= OP_MODE;
    end else if (state == ST_NEXT) begin
      src_ptr   <= src_step;
      dst_ptr   <= dst_step;
      remaining <= rem_after;
    end
  end

  // Control FSM with registered bus outputs.
  always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
    if (CSI_CLOCK_RESET) begin
      state          <= ST_IDLE;
      start_q        <= 1'b0;
      DONE           <= 1'b0;
      AVM_READ       <= 1'b0;
      AVM_WRITE      <= 1'b0;
      AVM_ADDRESS    <= '0;
      AVM_BURSTCOUNT <= '0;
      len            <= '0;
      wr_idx         <= '0;
      rd_idx         <= '0;
    end else begin
      start_q <= START;
      case (state)
        ST_IDLE, ST_FINISH: begin
          if (launch) begin
            DONE   <= 1'b0;
            len    <= burst_len(WORD_COUNT);
            wr_idx <= '0;
            if (WORD_COUNT == '0) begin
              state <= ST_FINISH;
            end else begin
              state          <= ST_RD_REQ;
              AVM_READ       <= 1'b1;
              AVM_ADDRESS    <= SRC_ADDR & ALIGN_MASK;
              AVM_BURSTCOUNT <= burst_len(WORD_COUNT);
            end
          end else if (state == ST_FINISH) begin
            DONE <= 1'b1;
          end
        end

        ST_RD_REQ: begin
          if (!AVM_WAITREQUEST) begin
            AVM_READ <= 1'b0;
            wr_idx   <= '0;
            state    <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (AVM_READDATAVALID) begin
            wr_idx <= wr_idx + BC_WIDTH'(1);
            if (wr_idx == len - BC_WIDTH'(1)) begin
              state          <= ST_WR_BURST;
              AVM_WRITE      <= 1'b1;
              AVM_ADDRESS    <= dst_ptr;
              AVM_BURSTCOUNT <= len;
              rd_idx         <= '0;
            end
          end
        end

        ST_WR_BURST: begin
          if (!AVM_WAITREQUEST) begin
            rd_idx <= rd_idx + BC_WIDTH'(1);
            if (rd_idx == len - BC_WIDTH'(1)) begin
              AVM_WRITE <= 1'b0;
              state     <= ST_NEXT;
            end
          end
        end

        ST_NEXT: begin
          if (rem_after == '0) begin
            state <= ST_FINISH;
          end else begin
            state          <= ST_RD_REQ;
            AVM_READ       <= 1'b1;
            AVM_ADDRESS    <= src_step;
            AVM_BURSTCOUNT <= burst_len(rem_after);
            len            <= burst_len(rem_after);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_burst_master.sv
module tb_accel_burst_master;
  import accel_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        START = 1'b0;
  logic [31:0] SRC_ADDR = '0;
  logic [31:0] DST_ADDR = '0;
  logic [31:0] WORD_COUNT = '0;
  logic [1:0]  OP_MODE = '0;
  logic        DONE;
  logic        BUSY;
  logic [31:0] AVM_ADDRESS;
  logic        AVM_READ;
  logic        AVM_WRITE;
  logic [3:0]  AVM_BURSTCOUNT;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST = 1'b0;
  logic [31:0] AVM_READDATA = '0;
  logic        AVM_READDATAVALID = 1'b0;

  always #5 clk = ~clk;

  accel_burst_master dut (
    .CSI_CLOCK_CLK     (clk),
    .CSI_CLOCK_RESET   (rst),
    .START             (START),
    .SRC_ADDR          (SRC_ADDR),
    .DST_ADDR          (DST_ADDR),
    .WORD_COUNT        (WORD_COUNT),
    .OP_MODE           (OP_MODE),
    .DONE              (DONE),
    .BUSY              (BUSY),
    .AVM_ADDRESS       (AVM_ADDRESS),
    .AVM_READ          (AVM_READ),
    .AVM_WRITE         (AVM_WRITE),
    .AVM_BURSTCOUNT    (AVM_BURSTCOUNT),
    .AVM_WRITEDATA     (AVM_WRITEDATA),
    .AVM_WAITREQUEST   (AVM_WAITREQUEST),
    .AVM_READDATA      (AVM_READDATA),
    .AVM_READDATAVALID (AVM_READDATAVALID)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] addr; logic [31:0] data; } beat_t;
  typedef struct { logic [31:0] addr; logic [31:0] len;  } burst_t;

  logic [31:0] mem [logic [31:0]];
  beat_t  exp_beats[$];
  burst_t exp_rd[$];
  burst_t exp_wr[$];

  // Bus model state
  int          rd_pend = 0;
  int          rd_lat = 0;
  logic [31:0] rd_addr = '0;
  int          wr_beat = 0;
  int          wr_len = 0;
  logic [31:0] wr_base = '0;
  int          rw_seen = 0;
  int          stall_target = 0;
  int          stall_used = 0;
  logic        held_wr = 1'b0;
  logic        held_rd = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [3:0]  hold_bc = '0;
  logic [31:0] hold_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdmem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] model_op(input logic [1:0] op, input logic [31:0] d);
    case (op)
      2'd0:    return d;
      2'd1:    return ~d;
      2'd2:    return {d[7:0], d[15:8], d[23:16], d[31:24]};
      default: return d + 32'd1;
    endcase
  endfunction

  // Avalon slave model: decisions made on the falling edge for the next rising edge.
  always @(negedge clk) begin
    logic  wreq;
    beat_t e;
    burst_t b;
    if (rst) begin
      rd_pend           = 0;
      wr_beat           = 0;
      held_wr           = 1'b0;
      held_rd           = 1'b0;
      AVM_WAITREQUEST   = 1'b0;
      AVM_READDATAVALID = 1'b0;
    end else begin
      if (held_wr) begin
        chk("hold_write", 32'(AVM_WRITE), 32'd1);
        chk("hold_wr_addr", AVM_ADDRESS, hold_addr);
        chk("hold_wr_bc", 32'(AVM_BURSTCOUNT), 32'(hold_bc));
        chk("hold_wr_data", AVM_WRITEDATA, hold_data);
      end
      if (held_rd) begin
        chk("hold_read", 32'(AVM_READ), 32'd1);
        chk("hold_rd_addr", AVM_ADDRESS, hold_addr);
        chk("hold_rd_bc", 32'(AVM_BURSTCOUNT), 32'(hold_bc));
      end
      if (AVM_READ || AVM_WRITE) rw_seen++;

      // read data return
      AVM_READDATAVALID = 1'b0;
      if (rd_pend > 0) begin
        if (rd_lat > 0) rd_lat--;
        else if ($urandom_range(0, 99) >= 20) begin
          AVM_READDATAVALID = 1'b1;
          AVM_READDATA      = rdmem(rd_addr);
          rd_addr           = rd_addr + 32'd4;
          rd_pend--;
        end
      end

      wreq = ($urandom_range(0, 99) < 30);
      if (AVM_WRITE && wr_beat == 2 && stall_used < stall_target) begin
        wreq = 1'b1;
        stall_used++;
      end
      AVM_WAITREQUEST = wreq;
      held_wr   = AVM_WRITE && wreq;
      held_rd   = AVM_READ && wreq;
      hold_addr = AVM_ADDRESS;
      hold_bc   = AVM_BURSTCOUNT;
      hold_data = AVM_WRITEDATA;

      if (AVM_READ && !wreq) begin
        chk("rd_burst_expected", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) begin
          b = exp_rd.pop_front();
          chk("rd_addr", AVM_ADDRESS, b.addr);
          chk("rd_bc", 32'(AVM_BURSTCOUNT), b.len);
        end
        rd_addr = AVM_ADDRESS;
        rd_pend = int'(AVM_BURSTCOUNT);
        rd_lat  = int'($urandom_range(2, 5)) - 1;
      end

      if (AVM_WRITE && !wreq) begin
        if (wr_beat == 0) begin
          chk("wr_burst_expected", 32'(exp_wr.size() > 0), 32'd1);
          if (exp_wr.size() > 0) begin
            b = exp_wr.pop_front();
            chk("wr_addr", AVM_ADDRESS, b.addr);
            chk("wr_bc", 32'(AVM_BURSTCOUNT), b.len);
          end
          wr_base = AVM_ADDRESS;
          wr_len  = int'(AVM_BURSTCOUNT);
        end
        chk("wr_addr_const", AVM_ADDRESS, wr_base);
        chk("wr_bc_const", 32'(AVM_BURSTCOUNT), 32'(wr_len));
        chk("wr_beat_expected", 32'(exp_beats.size() > 0), 32'd1);
        if (exp_beats.size() > 0) begin
          e = exp_beats.pop_front();
          chk("wr_data", AVM_WRITEDATA, e.data);
          chk("wr_beat_addr", wr_base + 32'(4 * wr_beat), e.addr);
        end
        mem[wr_base + 32'(4 * wr_beat)] = AVM_WRITEDATA;
        wr_beat++;
        if (wr_beat >= wr_len) wr_beat = 0;
      end
    end
  end

  task automatic push_expect(input logic [31:0] src, input logic [31:0] dst,
                             input int cnt, input logic [1:0] op);
    logic [31:0] s, d;
    int rem, off, l;
    s = src & ~32'h3;
    d = dst & ~32'h3;
    for (int i = 0; i < cnt; i++)
      exp_beats.push_back('{addr: d + 32'(4 * i), data: model_op(op, rdmem(s + 32'(4 * i)))});
    rem = cnt;
    off = 0;
    while (rem > 0) begin
      l = (rem > 8) ? 8 : rem;
      exp_rd.push_back('{addr: s + 32'(off), len: 32'(l)});
      exp_wr.push_back('{addr: d + 32'(off), len: 32'(l)});
      off += 4 * l;
      rem -= l;
    end
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                         input logic [1:0] op, input bit toggle);
    int c;
    push_expect(src, dst, cnt, op);
    @(negedge clk);
    SRC_ADDR = src; DST_ADDR = dst; WORD_COUNT = 32'(cnt); OP_MODE = op; START = 1'b1;
    @(posedge clk); #1;
    chk("launch_read", 32'(AVM_READ), 32'd1);
    chk("launch_busy", 32'(BUSY), 32'd1);
    chk("launch_done_clr", 32'(DONE), 32'd0);
    @(negedge clk);
    START = 1'b0;
    if (toggle) begin
      repeat (3) @(negedge clk);
      SRC_ADDR = 32'hBAD0_0000; DST_ADDR = 32'hBAD1_0000; WORD_COUNT = 32'd99; OP_MODE = 2'd1;
      START = 1'b1;
      @(negedge clk);
      chk("toggle_busy", 32'(BUSY), 32'd1);
      START = 1'b0;
      repeat (2) @(negedge clk);
      START = 1'b1;
      @(negedge clk);
      START = 1'b0;
    end
    c = 0;
    while (DONE !== 1'b1 && c < 4000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("job_done", 32'(DONE), 32'd1);
    chk("job_not_busy", 32'(BUSY), 32'd0);
    chk("beats_drained", 32'(exp_beats.size()), 32'd0);
    chk("rd_bursts_drained", 32'(exp_rd.size()), 32'd0);
    chk("wr_bursts_drained", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, seen;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read", 32'(AVM_READ), 32'd0);
    chk("rst_write", 32'(AVM_WRITE), 32'd0);
    chk("rst_addr", AVM_ADDRESS, 32'd0);
    chk("rst_bc", 32'(AVM_BURSTCOUNT), 32'd0);
    chk("rst_wdata", AVM_WRITEDATA, 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Simple 4-word copy
    for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'(i + 1);
    run_job(32'h100, 32'h200, 4, OP_COPY, 1'b0);
    for (int i = 0; i < 4; i++) chk("t1_mem", rdmem(32'h200 + 32'(4 * i)), 32'(i + 1));

    // 13 words, increment, bursts 8 + 5; inputs toggled mid-job
    mem[32'h1000] = 32'hFFFF_FFFF;
    for (int i = 1; i < 13; i++) mem[32'h1000 + 32'(4 * i)] = $urandom;
    mem[32'h1030] = 32'h0000_0041;
    run_job(32'h1000, 32'h2000, 13, OP_INC, 1'b1);
    chk("t2_wrap", rdmem(32'h2000), 32'h0000_0000);
    chk("t2_last", rdmem(32'h2030), 32'h0000_0042);
    chk("t2_beyond", rdmem(32'h2034), 32'hDEADBEEF);

    // NOT and byte-swap, including misaligned address inputs
    mem[32'h3000] = 32'h0000_FFFF;
    run_job(32'h3000, 32'h3100, 1, OP_NOT, 1'b0);
    chk("t3_not", rdmem(32'h3100), 32'hFFFF_0000);
    mem[32'h3200] = 32'h1122_3344;
    run_job(32'h3202, 32'h3303, 1, OP_BSWAP, 1'b0);
    chk("t3_bswap", rdmem(32'h3300), 32'h4433_2211);

    // Zero-length job
    seen = rw_seen;
    @(negedge clk);
    WORD_COUNT = 32'd0; START = 1'b1;
    @(posedge clk); #1;
    chk("t4_done_clr", 32'(DONE), 32'd0);
    chk("t4_busy", 32'(BUSY), 32'd0);
    @(posedge clk); #1;
    chk("t4_done", 32'(DONE), 32'd1);
    @(negedge clk);
    START = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_no_bus", 32'(rw_seen), 32'(seen));

    // Long write stall
    for (int i = 0; i < 8; i++) mem[32'h4000 + 32'(4 * i)] = $urandom;
    stall_target = 10;
    run_job(32'h4000, 32'h4100, 8, OP_COPY, 1'b0);
    chk("t5_stall_cycles", 32'(stall_used), 32'd10);

    // Reset during a write burst, then a clean job
    for (int i = 0; i < 10; i++) mem[32'h5000 + 32'(4 * i)] = $urandom;
    push_expect(32'h5000, 32'h5100, 10, OP_COPY);
    @(negedge clk);
    SRC_ADDR = 32'h5000; DST_ADDR = 32'h5100; WORD_COUNT = 32'd10; OP_MODE = OP_COPY;
    START = 1'b1;
    c = 0;
    while (AVM_WRITE !== 1'b1 && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("t6_reached_write", 32'(AVM_WRITE), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_write", 32'(AVM_WRITE), 32'd0);
    chk("t6_rst_read", 32'(AVM_READ), 32'd0);
    chk("t6_rst_addr", AVM_ADDRESS, 32'd0);
    chk("t6_rst_bc", 32'(AVM_BURSTCOUNT), 32'd0);
    chk("t6_rst_wdata", AVM_WRITEDATA, 32'd0);
    chk("t6_rst_busy", 32'(BUSY), 32'd0);
    exp_beats.delete();
    exp_rd.delete();
    exp_wr.delete();
    START = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_job(32'h5000, 32'h5100, 10, OP_BSWAP, 1'b0);
    chk("t6_first", rdmem(32'h5100), model_op(OP_BSWAP, rdmem(32'h5000)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
